// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core and its display driver:
// status encoding, conversion FSM states and seven-segment constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_ERROR   = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_LOAD,
        CV_SHIFT,
        CV_DONE
    } conv_state_e;

    localparam logic [7:0] MIN_MAX = 8'd99;
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERROR = 7'h3F;
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] res;
        res = SEG_BLANK;
        if (bcd <= 4'd9) res = SEG_TABLE[bcd];
        return res;
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Iterative double-dabble: 7-bit binary to two BCD digits in 8 shift cycles.
// done is high during the last shift; results are stable from the next cycle.
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [15:0] sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] adj;

    always_comb begin
        adj = sh_q;
        if (adj[11:8] >= 4'd5)  adj[11:8]  = adj[11:8] + 4'd3;
        if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;

        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (start) begin
            sh_d  = {8'h00, 1'b0, bin};
            cnt_d = 4'd8;
        end else if (cnt_q != 4'd0) begin
            sh_d  = {adj[14:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 4'd1);
    assign tens = sh_q[15:12];
    assign ones = sh_q[11:8];

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM:SS display driver with snapshot, BCD conversion,
// status-dependent separator/blink/error rendering and registered outputs.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [1:0]         idx_q, idx_d;
    logic               first_q, first_d;
    logic [6:0]         snap_min_q, snap_min_d;
    logic [5:0]         snap_sec_q, snap_sec_d;
    status_e            snap_st_q, snap_st_d;
    conv_state_e        state_q, state_d;
    logic [3:0][3:0]    dig_q, dig_d;
    status_e            disp_st_q, disp_st_d;
    logic               valid_q, valid_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         an_q, an_d;

    logic       slot_wrap, frame_wrap, snap_req, conv_start;
    logic       min_done, sec_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    assign slot_wrap  = (slot_q == SLOT_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_wrap && (idx_q == 2'd3);
    assign snap_req   = first_q || frame_wrap;

    bin2bcd_seq u_min_bcd (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin(snap_min_q),
        .done(min_done), .tens(min_tens), .ones(min_ones)
    );

    bin2bcd_seq u_sec_bcd (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin({1'b0, snap_sec_q}),
        .done(sec_done), .tens(sec_tens), .ones(sec_ones)
    );

    always_comb begin
        slot_d     = slot_wrap ? '0 : slot_q + SLOT_W'(1);
        idx_d      = slot_wrap ? idx_q + 2'd1 : idx_q;
        first_d    = 1'b0;
        snap_min_d = snap_min_q;
        snap_sec_d = snap_sec_q;
        snap_st_d  = snap_st_q;
        if (snap_req) begin
            snap_min_d = (minutes > MIN_MAX) ? MIN_MAX[6:0] : minutes[6:0];
            snap_sec_d = (seconds > SEC_MAX) ? SEC_MAX : seconds;
            snap_st_d  = status_e'(status);
        end
    end

    // Display registers change only in DONE, so a frame never mixes old and new digits.
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        dig_d      = dig_q;
        disp_st_d  = disp_st_q;
        valid_d    = valid_q;
        case (state_q)
            CV_IDLE:  if (snap_req) state_d = CV_LOAD;
            CV_LOAD: begin
                conv_start = 1'b1;
                state_d    = CV_SHIFT;
            end
            CV_SHIFT: if (min_done && sec_done) state_d = CV_DONE;
            CV_DONE: begin
                dig_d     = {min_tens, min_ones, sec_tens, sec_ones};
                disp_st_d = snap_st_q;
                valid_d   = 1'b1;
                state_d   = CV_IDLE;
            end
            default:  state_d = CV_IDLE;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (disp_st_q != ST_PAUSED) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = !blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (valid_q) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_encode(dig_q[idx_q]);
            case (disp_st_q)
                ST_RUNNING: dp_d = (idx_q != 2'd2);
                ST_PAUSED: begin
                    dp_d = (idx_q != 2'd2);
                    if (blink_off_q) an_d = 4'hF;
                end
                ST_ERROR:   seg_d = SEG_ERROR;
                default:    dp_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            snap_min_q  <= '0;
            snap_sec_q  <= '0;
            snap_st_q   <= ST_IDLE;
            state_q     <= CV_IDLE;
            dig_q       <= '0;
            disp_st_q   <= ST_IDLE;
            valid_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            snap_min_q  <= snap_min_d;
            snap_sec_q  <= snap_sec_d;
            snap_st_q   <= snap_st_d;
            state_q     <= state_d;
            dig_q       <= dig_d;
            disp_st_q   <= disp_st_d;
            valid_q     <= valid_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display (REFRESH_DIV=16, BLINK_DIV=2):
// expected outputs are queued against post-reset cycle numbers and compared at negedge.
module tb_stopwatch_display;

    localparam int RDIV = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] minutes = '0;
    logic [5:0] seconds = '0;
    logic [1:0] status = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clk = ~clk;

    stopwatch_display #(.REFRESH_DIV(RDIV), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds),
        .status(status), .seg(seg), .dp(dp), .an(an)
    );

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       chk_seg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int c, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic cs);
        exp_t e;
        e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.chk_seg = cs;
        sb.push_back(e);
    endtask

    task automatic push_blank(input int c);
        push(c, 4'hF, 7'h7F, 1'b1, 1'b1);
    endtask

    // Output at cycle c shows the digit selected after edge c-1.
    task automatic push_disp(input int c, input int m10, input int m1, input int s10,
                             input int s1, input logic [1:0] st, input logic off);
        int         idx;
        int         d [4];
        logic [3:0] a;
        logic [6:0] s;
        logic       p;
        idx = ((c - 1) / RDIV) % 4;
        d[0] = s1; d[1] = s10; d[2] = m1; d[3] = m10;
        a = off ? 4'hF : ~(4'b0001 << idx);
        s = (st == 2'b11) ? 7'h3F : seg_lut[d[idx]];
        p = !((st == 2'b01 || st == 2'b10) && idx == 2);
        push(c, a, s, p, !off);
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    chk($sformatf("sb_missed_c%0d", e.cyc), cyc, e.cyc);
                end else begin
                    chk($sformatf("c%0d_an", e.cyc), int'(an), int'(e.an));
                    chk($sformatf("c%0d_dp", e.cyc), int'(dp), int'(e.dp));
                    if (e.chk_seg) chk($sformatf("c%0d_seg", e.cyc), int'(seg), int'(e.seg));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < n) chk("wait_timeout", cyc, n);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, int'(an), 'hF);
        chk({tag, "_seg"}, int'(seg), 'h7F);
        chk({tag, "_dp"}, int'(dp), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp=done", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        minutes = 8'd12; seconds = 6'd35; status = 2'b01;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        push_blank(5);
        push_blank(11);
        push_disp(12, 1, 2, 3, 5, 2'b01, 1'b0);
        push_disp(20, 1, 2, 3, 5, 2'b01, 1'b0);
        push_disp(36, 1, 2, 3, 5, 2'b01, 1'b0);
        push_disp(52, 1, 2, 3, 5, 2'b01, 1'b0);
        rst_n = 1'b1;

        // Change inputs during slot 1 of the frame starting at edge 64, with clamping.
        wait_cyc(84);
        minutes = 8'd150; seconds = 6'd63; status = 2'b00;
        push_disp(100, 1, 2, 3, 5, 2'b01, 1'b0);
        push_disp(120, 1, 2, 3, 5, 2'b01, 1'b0);
        push_disp(138, 1, 2, 3, 5, 2'b01, 1'b0);
        push_disp(139, 9, 9, 5, 9, 2'b00, 1'b0);
        push_disp(160, 9, 9, 5, 9, 2'b00, 1'b0);
        push_disp(176, 9, 9, 5, 9, 2'b00, 1'b0);
        push_disp(192, 9, 9, 5, 9, 2'b00, 1'b0);

        wait_cyc(200);
        minutes = 8'd7; seconds = 6'd9; status = 2'b11;
        push_disp(266, 9, 9, 5, 9, 2'b00, 1'b0);
        push_disp(267, 0, 7, 0, 9, 2'b11, 1'b0);
        push_disp(290, 0, 7, 0, 9, 2'b11, 1'b0);

        // Pause shown from edge 330: lit until 448, dark 449..576, lit again from 577.
        wait_cyc(300);
        status = 2'b10;
        push_disp(340, 0, 7, 0, 9, 2'b10, 1'b0);
        push_disp(400, 0, 7, 0, 9, 2'b10, 1'b0);
        push_disp(420, 0, 7, 0, 9, 2'b10, 1'b0);
        push_disp(448, 0, 7, 0, 9, 2'b10, 1'b0);
        push_disp(449, 0, 7, 0, 9, 2'b10, 1'b1);
        push_disp(500, 0, 7, 0, 9, 2'b10, 1'b1);
        push_disp(576, 0, 7, 0, 9, 2'b10, 1'b1);
        push_disp(577, 0, 7, 0, 9, 2'b10, 1'b0);
        push_disp(580, 0, 7, 0, 9, 2'b10, 1'b0);

        wait_cyc(600);
        status = 2'b01;
        push_disp(660, 0, 7, 0, 9, 2'b01, 1'b0);
        push_disp(710, 0, 7, 0, 9, 2'b01, 1'b0);
        push_disp(770, 0, 7, 0, 9, 2'b01, 1'b0);

        // Snapshot at 832, conversion in SHIFT at 836 when reset hits.
        wait_cyc(780);
        minutes = 8'd42; seconds = 6'd17; status = 2'b01;
        wait_cyc(836);
        @(negedge clk);
        chk("sb_pre_reset", sb.size(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(negedge clk);
        push_blank(5);
        push_blank(11);
        push_disp(12, 4, 2, 1, 7, 2'b01, 1'b0);
        push_disp(20, 4, 2, 1, 7, 2'b01, 1'b0);
        push_disp(36, 4, 2, 1, 7, 2'b01, 1'b0);
        push_disp(52, 4, 2, 1, 7, 2'b01, 1'b0);
        rst_n = 1'b1;

        wait_cyc(60);
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
